data_mem_responder: RTL and testbench

Memory-side responder for the CPU data port: accepts load/store requests driven from the datapath (`alu_result` as address, `write_data` as store data), holds a word-organised SRAM, and returns load data with a programmable number of wait states. It sits between the datapath and the data memory array. It also provides the ready/valid handshake the pipeline stall logic will use once memory is no longer single-cycle.

---
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-port memory responder: word SRAM behind a ready/valid handshake with WAIT_STATES wait states.
// Optional byte-lane access (LDRB/STRB) is enabled by defining DATA_MEM_BYTE_ACCESS_EN.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        byte_q;

    logic [31:0] mem [2**DEPTH_LOG2];

    logic                  go;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_write;
    logic                  acc_byte;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic                  misaligned;
    logic                  do_store;
    logic [31:0]           rd_word;
    logic [31:0]           load_word;

    // With zero wait states the access happens on the accepting edge, so it uses the live inputs.
    always_comb begin
        go        = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_write = write_q;
        acc_byte  = byte_q;
        if (state == IDLE) begin
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_write = req_write;
            acc_byte  = req_byte;
            go        = !reset && req_valid && (WAIT_STATES == 0);
        end else if (state == WAIT) begin
            go = !reset && (cnt == 4'd1);
        end
    end

    assign idx  = acc_addr[DEPTH_LOG2+1:2];
    assign lane = acc_addr[1:0];

`ifdef DATA_MEM_BYTE_ACCESS_EN
    logic [31:0] lane_shifted;
    assign lane_shifted = rd_word >> {lane, 3'b000};
    assign misaligned   = !acc_byte && (lane != 2'b00);
    assign load_word    = acc_byte ? {24'h0, lane_shifted[7:0]} : rd_word;
`else
    assign misaligned   = (lane != 2'b00);
    assign load_word    = rd_word;
`endif

    assign rd_word   = mem[idx];
    assign do_store  = go && acc_write && !misaligned;
    assign req_ready = (state == IDLE) && !reset;

    // NOTE: the array has no reset; clearing it would force a flop-based implementation instead of SRAM.
    always_ff @(posedge clk) begin
        if (do_store) begin
`ifdef DATA_MEM_BYTE_ACCESS_EN
            if (acc_byte)
                mem[idx][{lane, 3'b000} +: 8] <= acc_wdata[7:0];
            else
                mem[idx] <= acc_wdata;
`else
            mem[idx] <= acc_wdata;
`endif
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            write_q   <= 1'b0;
            byte_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rdata     <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        write_q <= req_write;
                        byte_q  <= req_byte;
                        cnt     <= WAIT_INIT;
                        state   <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (go) begin
                rsp_valid <= 1'b1;
                rsp_err   <= misaligned;
                rdata     <= (acc_write || misaligned) ? 32'h0 : load_word;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses WAIT_STATES=2, instance 1 uses WAIT_STATES=0.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_write [2];
    logic        req_byte  [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rdata     [2];
    logic        rsp_err   [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_byte(req_byte[0]), .addr(addr[0]), .wdata(wdata[0]), .req_ready(req_ready[0]),
        .rsp_valid(rsp_valid[0]), .rdata(rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_byte(req_byte[1]), .addr(addr[1]), .wdata(wdata[1]), .req_ready(req_ready[1]),
        .rsp_valid(rsp_valid[1]), .rdata(rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on instance d; lat counts negedges from acceptance until rsp_valid is seen (20 = timeout).
    task automatic access(input int d, input logic wr, input logic bt, input logic [31:0] a,
                          input logic [31:0] w, output logic [31:0] rd, output logic err,
                          output int lat, output logic pulse_after, output logic ready_after);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_byte[d]  = bt;
        addr[d]      = a;
        wdata[d]     = w;
        @(posedge clk);
        rd  = 32'hx;
        err = 1'bx;
        lat = 20;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            req_valid[d] = 1'b0;
            if (rsp_valid[d]) begin
                rd  = rdata[d];
                err = rsp_err[d];
                lat = i;
                break;
            end
        end
        @(negedge clk);
        pulse_after = rsp_valid[d];
        ready_after = req_ready[d];
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        pa;
    logic        ra;
    int          seen;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_byte[i] = 1'b0;
            addr[i] = 32'h0; wdata[i] = 32'h0;
        end
        // Reset asserted together with a request: reset wins.
        reset        = 1'b1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        addr[0]      = 32'h20;
        wdata[0]     = 32'h5555_5555;
        repeat (2) @(negedge clk);
        check("ready_in_reset", {31'h0, req_ready[0]}, 32'h0);
        reset        = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'h0, req_ready[0]}, 32'h1);
        check("reset_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
        check("reset_rdata", rdata[0], 32'h0);
        check("reset_rsp_err", {31'h0, rsp_err[0]}, 32'h0);

        // Word store/load with two wait states.
        access(0, 1'b1, 1'b0, 32'h20, 32'h0000_000F, rd, err, lat, pa, ra);
        check("st20_latency", 32'(lat), 32'd3);
        check("st20_err", {31'h0, err}, 32'h0);
        check("st20_rdata", rd, 32'h0);
        check("st20_one_cycle", {31'h0, pa}, 32'h0);
        access(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, err, lat, pa, ra);
        check("ld20_latency", 32'(lat), 32'd3);
        check("ld20_rdata", rd, 32'h0000_000F);
        check("ld20_one_cycle", {31'h0, pa}, 32'h0);
        check("ld20_ready_after", {31'h0, ra}, 32'h1);

        // Misaligned word store is flagged and suppressed; high address bits alias.
        access(0, 1'b1, 1'b0, 32'h22, 32'hFFFF_FFFF, rd, err, lat, pa, ra);
        check("st22_err", {31'h0, err}, 32'h1);
        check("st22_rdata", rd, 32'h0);
        access(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, err, lat, pa, ra);
        check("ld20_after_st22", rd, 32'h0000_000F);
        access(0, 1'b0, 1'b0, 32'h420, 32'h0, rd, err, lat, pa, ra);
        check("ld420_alias", rd, 32'h0000_000F);
        check("ld420_err", {31'h0, err}, 32'h0);
        access(0, 1'b0, 1'b0, 32'h21, 32'h0, rd, err, lat, pa, ra);
        check("ld21_err", {31'h0, err}, 32'h1);
        check("ld21_rdata", rd, 32'h0);

        // Byte lanes.
        access(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, err, lat, pa, ra);
        access(0, 1'b1, 1'b0, 32'h40, 32'h1122_3344, rd, err, lat, pa, ra);
        check("st40_rdata_zero", rd, 32'h0);
        access(0, 1'b1, 1'b1, 32'h41, 32'hFFFF_FFAB, rd, err, lat, pa, ra);
`ifdef DATA_MEM_BYTE_ACCESS_EN
        check("strb41_err", {31'h0, err}, 32'h0);
`else
        check("strb41_err", {31'h0, err}, 32'h1);
`endif
        access(0, 1'b0, 1'b0, 32'h40, 32'h0, rd, err, lat, pa, ra);
`ifdef DATA_MEM_BYTE_ACCESS_EN
        check("ld40_word", rd, 32'h1122_AB44);
`else
        check("ld40_word", rd, 32'h1122_3344);
`endif
        access(0, 1'b0, 1'b1, 32'h43, 32'h0, rd, err, lat, pa, ra);
`ifdef DATA_MEM_BYTE_ACCESS_EN
        check("ldrb43_rdata", rd, 32'h0000_0011);
        check("ldrb43_err", {31'h0, err}, 32'h0);
`else
        check("ldrb43_rdata", rd, 32'h0);
        check("ldrb43_err", {31'h0, err}, 32'h1);
`endif

        // Reset during WAIT abandons an uncommitted store.
        access(0, 1'b1, 1'b0, 32'h80, 32'h0000_0001, rd, err, lat, pa, ra);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_byte[0]  = 1'b0;
        addr[0]      = 32'h80;
        wdata[0]     = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("wait_ready_low", {31'h0, req_ready[0]}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        @(negedge clk);
        check("post_reset_ready", {31'h0, req_ready[0]}, 32'h1);
        if (rsp_valid[0]) seen++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        check("post_reset_no_rsp", 32'(seen), 32'd0);
        access(0, 1'b0, 1'b0, 32'h80, 32'h0, rd, err, lat, pa, ra);
        check("ld80_old_value", rd, 32'h0000_0001);

        // Zero wait states.
        access(1, 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, rd, err, lat, pa, ra);
        check("ws0_st_latency", 32'(lat), 32'd1);
        access(1, 1'b0, 1'b0, 32'h10, 32'h0, rd, err, lat, pa, ra);
        check("ws0_ld_latency", 32'(lat), 32'd1);
        check("ws0_ld_rdata", rd, 32'hCAFE_F00D);
        check("ws0_one_cycle", {31'h0, pa}, 32'h0);

        // A request held high is accepted again only after RESP returns to IDLE.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        addr[1]      = 32'h10;
        @(posedge clk);
        @(negedge clk);
        check("held_rsp1", {31'h0, rsp_valid[1]}, 32'h1);
        check("held_resp_ready", {31'h0, req_ready[1]}, 32'h0);
        @(negedge clk);
        check("held_gap_rsp", {31'h0, rsp_valid[1]}, 32'h0);
        check("held_idle_ready", {31'h0, req_ready[1]}, 32'h1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("held_rsp2", {31'h0, rsp_valid[1]}, 32'h1);
        check("held_rsp2_rdata", rdata[1], 32'hCAFE_F00D);
        @(negedge clk);
        check("held_rsp2_one_cycle", {31'h0, rsp_valid[1]}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
